// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the rv32i core
module cpu_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_reg_write,
  input  logic             dec_halt,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic              ld_q, ld_d, st_q, st_d, rw_q, rw_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d, instr_q, instr_d;
  logic              wd_expired;

  // Timer reaching TIMEOUT means TIMEOUT wait cycles have already been granted.
  assign wd_expired = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    ld_d     = ld_q;
    st_d     = st_q;
    rw_d     = rw_q;
    timer_d  = '0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DECODE: begin
        ld_d = dec_mem_read;
        st_d = dec_mem_write;
        rw_d = dec_reg_write;
        if (dec_halt)                          state_d = S_HALT;
        else if (dec_mem_read && dec_mem_write) state_d = S_ERR;
        else                                   state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ld_q || st_q) begin
          state_d = S_MEM;
        end else if (rw_q) begin
          state_d = S_WB;
        end else begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = st_q;
        if (dmem_ready) begin
          // Stores retire here and never reach WB, so rf_we stays low for them.
          if (st_q) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_expired) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
  assign halted  = (state_q == S_HALT);
  assign error   = (state_q == S_ERR);
  assign state   = state_q;
  assign cycle_d = cycle_q + CNT_W'(busy);
  assign instr_d = instr_q + CNT_W'(pc_we);
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      rw_q    <= 1'b0;
      timer_q <= '0;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      rw_q    <= rw_d;
      timer_q <= timer_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

endmodule
